// File: rtl/vdec_ctrl_mc_if.sv
// vdec_ctrl_mc_if: control bundle between the job scheduler / decoder engines and
// the multi-candidate Viterbi decode controller.
// master: scheduler and engines side. slave: the controller.
interface vdec_ctrl_mc_if #(
  parameter int unsigned IDX_W = 2,
  parameter int unsigned TO_W  = 16
);
  // Scheduler side
  logic             start;
  logic             abort;
  logic [1:0]       mode;
  logic [IDX_W-1:0] crc_num;
  logic [TO_W-1:0]  to_limit;
  logic             busy;
  logic             done;
  logic             fail;
  logic             timeout;
  logic [IDX_W-1:0] match_idx;
  // Engine handshakes
  logic             fwd_start;
  logic             fwd_done;
  logic             bwd_start;
  logic             bwd_done;
  logic             crc_start;
  logic             crc_done;
  logic             crc_match;
  logic [IDX_W-1:0] crc_sel;
  logic             ser_start;
  logic             ser_done;
  logic [2:0]       fsm_out;

  modport master (
    output start, abort, mode, crc_num, to_limit,
    output fwd_done, bwd_done, crc_done, crc_match, ser_done,
    input  busy, done, fail, timeout, match_idx,
    input  fwd_start, bwd_start, crc_start, crc_sel, ser_start, fsm_out
  );

  modport slave (
    input  start, abort, mode, crc_num, to_limit,
    input  fwd_done, bwd_done, crc_done, crc_match, ser_done,
    output busy, done, fail, timeout, match_idx,
    output fwd_start, bwd_start, crc_start, crc_sel, ser_start, fsm_out
  );
endinterface

// File: rtl/vdec_ctrl_mc.sv
// vdec_ctrl_mc: sequences forward, traceback, CRC (up to NUM_CRC candidate masks)
// and SER engines for one decode job, with abort and fail/match status.
// Optional per-stage watchdog enabled by defining VDEC_CTRL_WDOG_EN.
module vdec_ctrl_mc #(
  parameter int unsigned NUM_CRC = 4,
  parameter int unsigned IDX_W   = 2,
  parameter int unsigned TO_W    = 16
) (
  input logic           clk,
  input logic           rst,
  vdec_ctrl_mc_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFwd    = 3'd1,
    StBwd    = 3'd2,
    StCrc    = 3'd3,
    StSer    = 3'd4,
    StFinish = 3'd5
  } state_e;

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_CRC - 1);

  state_e           state_q, state_d;
  logic [1:0]       mode_q;
  logic [IDX_W-1:0] limit_q, limit_d;
  logic [IDX_W-1:0] crc_sel_q;
  logic [IDX_W-1:0] match_q;
  logic             fail_q, to_q;
  logic             fwd_start_q, bwd_start_q, crc_start_q, ser_start_q;

  logic accept;      // start taken in IDLE
  logic retry;       // CRC miss with candidates left
  logic entering;    // state entry this cycle, CRC retry counts as re-entry
  logic set_fail, set_to, set_match;
  logic wdog_hit;

  // Last candidate index for the job; only multi-candidate mode uses more than one.
  always_comb begin
    limit_d = '0;
    if (bus.mode == 2'b10) begin
      if (32'(bus.crc_num) >= NUM_CRC) begin
        limit_d = LastIdx;
      end else begin
        limit_d = bus.crc_num;
      end
    end
  end

  // Next-state and status-event decode; abort beats done, done beats the watchdog.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    retry     = 1'b0;
    set_fail  = 1'b0;
    set_to    = 1'b0;
    set_match = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StFwd;
          accept  = 1'b1;
        end
      end
      StFwd: begin
        if (bus.abort) begin
          state_d  = StFinish;
          set_fail = 1'b1;
        end else if (bus.fwd_done) begin
          state_d = StBwd;
        end else if (wdog_hit) begin
          state_d  = StFinish;
          set_fail = 1'b1;
          set_to   = 1'b1;
        end
      end
      StBwd: begin
        if (bus.abort) begin
          state_d  = StFinish;
          set_fail = 1'b1;
        end else if (bus.bwd_done) begin
          state_d = (mode_q == 2'b00) ? StSer : StCrc;
        end else if (wdog_hit) begin
          state_d  = StFinish;
          set_fail = 1'b1;
          set_to   = 1'b1;
        end
      end
      StCrc: begin
        if (bus.abort) begin
          state_d  = StFinish;
          set_fail = 1'b1;
        end else if (bus.crc_done) begin
          if (bus.crc_match) begin
            set_match = 1'b1;
            state_d   = (mode_q == 2'b11) ? StFinish : StSer;
          end else if (crc_sel_q < limit_q) begin
            retry = 1'b1;
          end else begin
            state_d  = StFinish;
            set_fail = 1'b1;
          end
        end else if (wdog_hit) begin
          state_d  = StFinish;
          set_fail = 1'b1;
          set_to   = 1'b1;
        end
      end
      StSer: begin
        if (bus.abort) begin
          state_d  = StFinish;
          set_fail = 1'b1;
        end else if (bus.ser_done) begin
          state_d = StFinish;
        end else if (wdog_hit) begin
          state_d  = StFinish;
          set_fail = 1'b1;
          set_to   = 1'b1;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  assign entering = (state_d != state_q) | retry;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Job configuration latched on start accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= 2'b00;
      limit_q <= '0;
    end else if (accept) begin
      mode_q  <= bus.mode;
      limit_q <= limit_d;
    end
  end

  // Candidate index: cleared on accept and CRC entry, stepped per retry, held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_sel_q <= '0;
    end else if (accept) begin
      crc_sel_q <= '0;
    end else if (retry) begin
      crc_sel_q <= crc_sel_q + IDX_W'(1);
    end else if (state_q == StBwd && state_d == StCrc) begin
      crc_sel_q <= '0;
    end
  end

  // Status: cleared on accept, set by terminating events, held until the next job.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_q  <= 1'b0;
      to_q    <= 1'b0;
      match_q <= '0;
    end else if (accept) begin
      fail_q  <= 1'b0;
      to_q    <= 1'b0;
      match_q <= '0;
    end else begin
      if (set_fail) begin
        fail_q <= 1'b1;
      end
      if (set_to) begin
        to_q <= 1'b1;
      end
      if (set_match) begin
        match_q <= crc_sel_q;
      end
    end
  end

  // Engine start pulses: one cycle, high in the first cycle of the entered state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_start_q <= 1'b0;
      bwd_start_q <= 1'b0;
      crc_start_q <= 1'b0;
      ser_start_q <= 1'b0;
    end else begin
      fwd_start_q <= entering && (state_d == StFwd);
      bwd_start_q <= entering && (state_d == StBwd);
      crc_start_q <= entering && (state_d == StCrc);
      ser_start_q <= entering && (state_d == StSer);
    end
  end

`ifdef VDEC_CTRL_WDOG_EN
  logic [TO_W-1:0] wdog_q;
  logic            active;

  assign active   = (state_q == StFwd) || (state_q == StBwd) ||
                    (state_q == StCrc) || (state_q == StSer);
  assign wdog_hit = active && (bus.to_limit != '0) && (wdog_q == bus.to_limit);

  // Per-stage cycle counter, restarted on every entry including CRC retries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_q <= '0;
    end else if (entering) begin
      wdog_q <= '0;
    end else if (active) begin
      wdog_q <= wdog_q + TO_W'(1);
    end
  end
`else
  logic unused_to_limit;

  assign wdog_hit        = 1'b0;
  assign unused_to_limit = ^bus.to_limit;
`endif

  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = (state_q == StFinish);
  assign bus.fail      = fail_q;
  assign bus.timeout   = to_q;
  assign bus.match_idx = match_q;
  assign bus.fwd_start = fwd_start_q;
  assign bus.bwd_start = bwd_start_q;
  assign bus.crc_start = crc_start_q;
  assign bus.ser_start = ser_start_q;
  assign bus.crc_sel   = crc_sel_q;
  assign bus.fsm_out   = state_q;

endmodule

// File: tb/tb_vdec_ctrl_mc.sv
// tb_vdec_ctrl_mc: directed test of vdec_ctrl_mc with a small engine responder.
module tb_vdec_ctrl_mc;

  localparam int unsigned IDX_W = 3;
  localparam int unsigned TO_W  = 16;

  logic clk;
  logic rst;

  vdec_ctrl_mc_if #(.IDX_W(IDX_W), .TO_W(TO_W)) bus ();

  vdec_ctrl_mc #(.NUM_CRC(4), .IDX_W(IDX_W), .TO_W(TO_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Responder configuration: cycles from start pulse to done, -1 = never.
  int fwd_dly = 0, bwd_dly = 0, crc_dly = 0, ser_dly = 0;
  logic [7:0] match_tab = 8'h00;
  int fwd_cnt = -1, bwd_cnt = -1, crc_cnt = -1, ser_cnt = -1;
  int n_fwd = 0, n_bwd = 0, n_crc = 0, n_ser = 0, n_done = 0;
  int sel_log [8];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Engine model: sees start pulses mid-cycle and raises done after the programmed delay.
  always @(negedge clk) begin
    bus.fwd_done  = 1'b0;
    bus.bwd_done  = 1'b0;
    bus.crc_done  = 1'b0;
    bus.crc_match = 1'b0;
    bus.ser_done  = 1'b0;
    if (rst) begin
      fwd_cnt = -1;
      bwd_cnt = -1;
      crc_cnt = -1;
      ser_cnt = -1;
    end else begin
      if (bus.done) n_done++;
      if (fwd_cnt > 0) fwd_cnt--;
      if (bwd_cnt > 0) bwd_cnt--;
      if (crc_cnt > 0) crc_cnt--;
      if (ser_cnt > 0) ser_cnt--;
      if (bus.fwd_start) begin fwd_cnt = fwd_dly; n_fwd++; end
      if (bus.bwd_start) begin bwd_cnt = bwd_dly; n_bwd++; end
      if (bus.crc_start) begin
        crc_cnt = crc_dly;
        if (n_crc < 8) sel_log[n_crc] = int'(bus.crc_sel);
        n_crc++;
      end
      if (bus.ser_start) begin ser_cnt = ser_dly; n_ser++; end
      if (fwd_cnt == 0) begin bus.fwd_done = 1'b1; fwd_cnt = -1; end
      if (bwd_cnt == 0) begin bus.bwd_done = 1'b1; bwd_cnt = -1; end
      if (crc_cnt == 0) begin
        bus.crc_done  = 1'b1;
        bus.crc_match = match_tab[bus.crc_sel];
        crc_cnt = -1;
      end
      if (ser_cnt == 0) begin bus.ser_done = 1'b1; ser_cnt = -1; end
    end
  end

  task automatic clear_counts();
    n_fwd  = 0;
    n_bwd  = 0;
    n_crc  = 0;
    n_ser  = 0;
    n_done = 0;
    for (int i = 0; i < 8; i++) sel_log[i] = -1;
  endtask

  // Issue one job and return the cycle (start accept = cycle 0) where done is seen, -1 if never.
  task automatic run_job(input logic [1:0] m, input logic [IDX_W-1:0] cn,
                         input logic [TO_W-1:0] lim, output int done_cyc);
    clear_counts();
    bus.mode     = m;
    bus.crc_num  = cn;
    bus.to_limit = lim;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    done_cyc  = -1;
    for (int i = 1; i < 200; i++) begin
      if (bus.done) begin
        done_cyc = i;
        break;
      end
      tick();
    end
  endtask

  int dc;

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.mode     = 2'b00;
    bus.crc_num  = '0;
    bus.to_limit = '0;
    clear_counts();
    tick();
    tick();
    // Reset state
    check_eq("rst_fsm", 32'(bus.fsm_out), 0);
    check_eq("rst_outs", 32'({bus.busy, bus.done, bus.fail, bus.timeout, bus.fwd_start,
                              bus.bwd_start, bus.crc_start, bus.ser_start}), 0);
    check_eq("rst_idx", 32'({bus.match_idx, bus.crc_sel}), 0);
    rst = 1'b0;
    tick();

    // Mode 00, engines answer 3 cycles after each start
    fwd_dly = 3; bwd_dly = 3; ser_dly = 3; crc_dly = 3;
    clear_counts();
    bus.mode  = 2'b00;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_eq("m00_fwd_entry", 32'({bus.fsm_out, bus.fwd_start, bus.busy}), 32'({3'd1, 1'b1, 1'b1}));
    for (int i = 1; i < 200; i++) begin
      dc = i;
      if (bus.done) break;
      tick();
    end
    check_eq("m00_done_cyc", 32'(dc), 13);
    check_eq("m00_pulses", 32'({n_fwd[3:0], n_bwd[3:0], n_crc[3:0], n_ser[3:0]}), 32'h1101);
    check_eq("m00_fail", 32'(bus.fail), 0);
    tick();
    check_eq("m00_idle", 32'({bus.busy, bus.done, bus.fsm_out}), 0);

    // Mode 00, done inputs answer at once: minimum latency
    fwd_dly = 0; bwd_dly = 0; ser_dly = 0; crc_dly = 0;
    run_job(2'b00, '0, '0, dc);
    check_eq("m00_min_done_cyc", 32'(dc), 4);
    tick();

    // Mode 10, three candidates, only the third matches
    fwd_dly = 1; bwd_dly = 1; crc_dly = 1; ser_dly = 1;
    match_tab = 8'b0000_0100;
    run_job(2'b10, 3'd2, '0, dc);
    check_eq("m10_done_cyc", 32'(dc), 13);
    check_eq("m10_n_crc", 32'(n_crc), 3);
    check_eq("m10_sels", 32'({sel_log[0][3:0], sel_log[1][3:0], sel_log[2][3:0]}), 32'h012);
    check_eq("m10_match_idx", 32'(bus.match_idx), 2);
    check_eq("m10_ser_fail", 32'({n_ser[3:0], bus.fail}), 32'({4'd1, 1'b0}));
    tick();

    // Mode 11, first candidate matches: no SER, match index cleared then written 0
    fwd_dly = 0; bwd_dly = 0; crc_dly = 0; ser_dly = 0;
    match_tab = 8'b0000_0001;
    run_job(2'b11, 3'd2, '0, dc);
    check_eq("m11_done_cyc", 32'(dc), 4);
    check_eq("m11_n_ser", 32'(n_ser), 0);
    check_eq("m11_status", 32'({bus.match_idx, bus.fail}), 0);
    tick();

    // Mode 01, no match: single attempt even with crc_num set, then fail
    match_tab = 8'h00;
    run_job(2'b01, 3'd3, '0, dc);
    check_eq("m01_done_cyc", 32'(dc), 4);
    check_eq("m01_counts", 32'({n_crc[3:0], n_ser[3:0]}), 32'h10);
    check_eq("m01_fail", 32'(bus.fail), 1);
    tick();
    check_eq("m01_fail_held", 32'({bus.busy, bus.fail}), 32'b01);

    // Abort together with bwd_done; a start while busy is ignored
    fwd_dly = 0; bwd_dly = 2;
    clear_counts();
    bus.mode    = 2'b10;
    bus.crc_num = 3'd1;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check_eq("abt_bwd_entry", 32'({bus.fsm_out, bus.bwd_start}), 32'({3'd2, 1'b1}));
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_eq("busy_start_ignored", 32'({bus.fsm_out, bus.fwd_start}), 32'({3'd2, 1'b0}));
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_eq("abt_finish", 32'({bus.fsm_out, bus.done, bus.fail, bus.timeout}),
             32'({3'd5, 1'b1, 1'b1, 1'b0}));
    tick();
    check_eq("abt_counts", 32'({n_fwd[3:0], n_crc[3:0], n_ser[3:0]}), 32'h100);

    // crc_num above NUM_CRC-1 clamps to four attempts
    bwd_dly = 0; crc_dly = 0;
    match_tab = 8'h00;
    run_job(2'b10, 3'd7, '0, dc);
    check_eq("clamp_done_cyc", 32'(dc), 7);
    check_eq("clamp_n_crc", 32'(n_crc), 4);
    check_eq("clamp_last_sel", 32'(sel_log[3]), 3);
    check_eq("clamp_fail", 32'(bus.fail), 1);
    tick();

`ifdef VDEC_CTRL_WDOG_EN
    // Watchdog: forward engine stalls, limit 5
    fwd_dly = -1;
    run_job(2'b00, '0, 16'd5, dc);
    check_eq("wdog_done_cyc", 32'(dc), 7);
    check_eq("wdog_status", 32'({bus.timeout, bus.fail}), 32'b11);
    tick();
    // Limit 0 disables the watchdog
    clear_counts();
    bus.to_limit = '0;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    check_eq("wdog_off_stall", 32'(bus.fsm_out), 1);
`else
    // No watchdog build: a stalled stage waits regardless of to_limit
    fwd_dly = -1;
    clear_counts();
    bus.mode     = 2'b00;
    bus.to_limit = 16'd5;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check_eq("nowdog_stall", 32'(bus.fsm_out), 1);
`endif
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_eq("stall_abort", 32'({bus.done, bus.fail, bus.timeout}), 32'b110);
    tick();
    fwd_dly = 0;

    // Reset in the middle of a CRC retry sequence
    crc_dly = 1;
    match_tab = 8'h00;
    clear_counts();
    bus.mode    = 2'b10;
    bus.crc_num = 3'd3;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    dc = -1;
    for (int i = 0; i < 50; i++) begin
      if (bus.crc_sel == 3'd2) begin
        dc = i;
        break;
      end
      tick();
    end
    check_eq("rstmid_reached_sel2", 32'(dc >= 0), 1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("rstmid_fsm", 32'({bus.fsm_out, bus.busy}), 0);
    check_eq("rstmid_outs", 32'({bus.crc_sel, bus.match_idx, bus.crc_start, bus.done,
                                 bus.fail}), 0);
    tick();
    rst = 1'b0;
    n_done = 0;
    tick();
    tick();
    tick();
    check_eq("rstmid_no_done", 32'({n_done[3:0], 1'b0, bus.fsm_out}), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop if the sequence above ever stalls.
  initial begin
    #200000;
    $display("FAIL global_timeout: got stalled expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/vdec_ctrl_mc.md
# vdec_ctrl_mc

Parametrised multi-candidate controller for the Viterbi decoder datapath: it sequences forward, traceback, CRC and SER engines for one decode job. It generalises the fixed two-pass HS decode control to up to NUM_CRC CRC candidate masks and a CRC-only mode, and adds abort with a fail/match status report. It sits between the job scheduler (start/busy/done) and the vdec_fwd/bwd, crc and ser engines.

## Interface
- NUM_CRC, 4: maximum CRC candidates per job (1..2**IDX_W)
- IDX_W, 2: candidate index width
- TO_W, 16: watchdog counter width
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  job request, accepted only in IDLE
- abort  in  1  terminate current job
- mode  in  2  00 no CRC; 01 single CRC; 10 multi-candidate CRC; 11 CRC only, no SER
- crc_num  in  IDX_W  candidates minus 1 (mode 10 only), sampled at start
- to_limit  in  TO_W  per-stage watchdog limit, 0 = disabled
- busy  out  1  fsm != IDLE
- done  out  1  one-cycle pulse in FINISH
- fail  out  1  job ended with no match, abort or timeout
- timeout  out  1  job ended by watchdog
- match_idx  out  IDX_W  candidate that matched
- fwd_start / fwd_done  out/in  1  forward engine handshake
- bwd_start / bwd_done  out/in  1  traceback handshake
- crc_start / crc_done / crc_match  out/in/in  1  CRC handshake and result
- crc_sel  out  IDX_W  current candidate mask index
- ser_start / ser_done  out/in  1  SER handshake
- fsm_out  out  3  current state

## Operation
- States: IDLE=0, FWD=1, BWD=2, CRC=3, SER=4, FINISH=5; codes 6/7 go to IDLE.
- IDLE: start -> FWD; mode and crc_num are latched. crc_num >= NUM_CRC clamps to NUM_CRC-1. Modes 01/11 force a limit of 0.
- FWD: fwd_done -> BWD.
- BWD: bwd_done -> SER if mode 00, otherwise CRC with crc_sel = 0.
- CRC: on crc_done:
  - match: mode 11 -> FINISH, otherwise -> SER; match_idx <= crc_sel.
  - no match and crc_sel < limit: crc_sel+1, stay in CRC, new crc_start.
  - no match and crc_sel = limit: FINISH with fail = 1.
- SER: ser_done -> FINISH.
- FINISH: -> IDLE unconditionally.
- abort: in FWD/BWD/CRC/SER it goes to FINISH with fail = 1. It has priority over any *_done in the same cycle. In IDLE and FINISH it is ignored.
- Start pulses are registered, one cycle each, and are high in the first cycle of the entered state (including each CRC retry). They are never asserted on entry to FINISH.
- crc_sel is held outside CRC and cleared on start accept.
- Status outputs (fail, timeout, match_idx) are written on entry to FINISH, held until the next accepted start, then cleared.
- start while busy is ignored. Mode 11 never issues ser_start.
- Reset: fsm = IDLE and every output 0, including crc_sel and match_idx. Reset mid-job drops the job with no done pulse.

## Timing
- Start accepted at cycle 0: fsm = FWD and fwd_start = 1 at cycle 1.
- *_done sampled at cycle k: next state and its start pulse at cycle k+1.
- done is high the cycle after the terminating event, then busy = 0 one cycle later.
- Minimum start-to-done, mode 00 with done inputs tied high: done at cycle 4.
- A done input arriving in the same cycle as its start pulse is accepted.
- Each extra CRC candidate costs at least 1 cycle.

## Configuration
- VDEC_CTRL_WDOG_EN defined:
  - A TO_W-bit counter clears on every state entry, including a CRC retry, and increments in FWD/BWD/CRC/SER.
  - When the count equals a non-zero to_limit with no done input that cycle, fsm goes to FINISH with fail = 1 and timeout = 1.
  - Abort has priority over the watchdog.
- Undefined: no counter; to_limit is ignored and timeout is tied 0.

## Test plan
- mode 00, done inputs return 3 cycles after each start -> fwd, bwd, ser pulses in order, no crc_start, done with fail = 0.
- mode 10, crc_num = 2, crc_match only on the 3rd result -> crc_sel 0, 1, 2 with three crc_start pulses, match_idx = 2, ser_start, fail = 0.
- mode 01, crc_match = 0 -> one crc_start, FINISH, fail = 1, no ser_start. mode 11 with match -> FINISH, no ser_start, match_idx = 0.
- abort in the same cycle as bwd_done -> FINISH next cycle, fail = 1, no crc_start or ser_start. start during busy is ignored.
- Watchdog build, to_limit = 5, fwd_done never asserted -> done 6 cycles after FWD entry, timeout = 1, fail = 1. to_limit = 0 -> no timeout.
- rst asserted in CRC -> all outputs 0 immediately, IDLE. crc_num = 7 with NUM_CRC = 4 -> at most 4 CRC attempts.
